// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART transmitter and receiver.
package uart_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } uart_state_e;

  localparam logic START_BIT_VALUE   = 1'b0;
  localparam logic STOP_BIT_VALUE    = 1'b1;
  localparam int   DATA_BITS         = 8;
  localparam int   BASE_FRAME_BITS   = 10;
  localparam int   MIN_CLOCK_DIVIDER = 2;
  localparam int   BIT_IDX_W         = 4;

endpackage

// File: rtl/uart_bit_timer.sv
// Reloadable down-counter; ticks while enabled and at zero, then reloads itself.
module uart_bit_timer #(
  parameter int WIDTH = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_reload,
  input  logic             i_enable,
  output logic             o_tick
);

  logic [WIDTH-1:0] r_count;
  logic             w_zero;

  assign w_zero = (r_count == '0);
  assign o_tick = i_enable && w_zero;

  always_ff @(posedge i_clock) begin
    if (i_reset)       r_count <= '0;
    else if (i_load)   r_count <= i_reload;
    else if (i_enable) r_count <= w_zero ? i_reload : r_count - 1'b1;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_DIVIDER_WIDTH = 16
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
  input  logic [7:0]                     data_i,
  input  logic                           start_i,
  input  logic                           parity_bit_i,
  input  logic                           parity_even_i,
  output logic                           serial_o,
  output logic                           ready_o,
  output logic                           done_o
);

  localparam logic [CLOCK_DIVIDER_WIDTH-1:0] L_MIN_DIV =
    CLOCK_DIVIDER_WIDTH'(MIN_CLOCK_DIVIDER);

  uart_state_e          r_state, w_state_nxt;
  logic [BIT_IDX_W-1:0] r_idx, w_idx_nxt;
  logic [7:0]           r_data, w_data_nxt;
  logic                 r_par_en, w_par_en_nxt;
  logic                 r_par_even, w_par_even_nxt;
  logic                 r_serial, w_serial_nxt;
  logic                 r_done, w_done_nxt;

  logic                           w_accept;
  logic                           w_tick;
  logic [CLOCK_DIVIDER_WIDTH-1:0] w_reload;
  logic [BIT_IDX_W-1:0]           w_last_idx;
  logic [BIT_IDX_W-1:0]           w_bit_idx;
  logic [2:0]                     w_data_sel;
  logic                           w_frame_bit;

  assign w_accept   = (r_state == ST_IDLE) && start_i && (clock_divider_i >= L_MIN_DIV);
  assign w_reload   = clock_divider_i - 1'b1;
  assign w_last_idx = BIT_IDX_W'(BASE_FRAME_BITS - 1) + {{(BIT_IDX_W-1){1'b0}}, r_par_en};
  assign w_bit_idx  = r_idx + 1'b1;
  assign w_data_sel = 3'(w_bit_idx - 1'b1);

  uart_bit_timer #(.WIDTH(CLOCK_DIVIDER_WIDTH)) u_bit_timer (
    .i_clock  (clock_i),
    .i_reset  (reset_i),
    .i_load   (w_accept),
    .i_reload (w_reload),
    .i_enable (r_state == ST_SEND),
    .o_tick   (w_tick)
  );

  // Value of the frame bit that starts at the next bit boundary.
  always_comb begin
    w_frame_bit = STOP_BIT_VALUE;
    if (w_bit_idx >= 4'd1 && w_bit_idx <= BIT_IDX_W'(DATA_BITS))
      w_frame_bit = r_data[w_data_sel];
    else if (w_bit_idx == BIT_IDX_W'(DATA_BITS + 1) && r_par_en)
      w_frame_bit = r_par_even ? (^r_data) : ~(^r_data);
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_data_nxt     = r_data;
    w_par_en_nxt   = r_par_en;
    w_par_even_nxt = r_par_even;
    w_serial_nxt   = r_serial;
    w_done_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_serial_nxt = STOP_BIT_VALUE;
        if (w_accept) begin
          w_data_nxt     = data_i;
          w_par_en_nxt   = parity_bit_i;
          w_par_even_nxt = parity_even_i;
          w_serial_nxt   = START_BIT_VALUE;
          w_idx_nxt      = '0;
          w_state_nxt    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_tick) begin
          if (r_idx == w_last_idx) begin
            w_state_nxt  = ST_IDLE;
            w_serial_nxt = STOP_BIT_VALUE;
            w_idx_nxt    = '0;
            w_done_nxt   = 1'b1;
          end else begin
            w_idx_nxt    = w_bit_idx;
            w_serial_nxt = w_frame_bit;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par_even <= 1'b0;
      r_serial   <= STOP_BIT_VALUE;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_data     <= w_data_nxt;
      r_par_en   <= w_par_en_nxt;
      r_par_even <= w_par_even_nxt;
      r_serial   <= w_serial_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign serial_o = r_serial;
  assign ready_o  = (r_state == ST_IDLE);
  assign done_o   = r_done;

endmodule
